wb_scoreboard_stage: RTL and testbench

- Write-side partner of the 16x32 register file. Holds the MEM/WB pipeline register and selects the writeback value.
- Drives the register file write port: WB_EN, destWB, valueWB. The register file commits on the falling clock edge.
- Keeps a per-register pending-write scoreboard. The decode stage uses its hazard output to stall when an operand's write has not yet committed.

---
 rtl/wb_scoreboard_stage_pkg.sv | 15 +
 rtl/wb_scoreboard.sv | 69 ++++++
 rtl/wb_scoreboard_stage.sv | 81 ++++++++
 tb/tb_wb_scoreboard_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_scoreboard_stage_pkg.sv
// Shared widths and index type for the MEM/WB writeback stage and its
// pending-write scoreboard.
package wb_scoreboard_stage_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 16;
  localparam int REG_W  = $clog2(NREG);
  localparam int CNT_W  = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef logic [REG_W-1:0] reg_idx_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register in-flight write counters, the decode hazard check and the
// sticky overflow/underflow flags.
module wb_scoreboard
  import wb_scoreboard_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [REG_W-1:0] inc_idx,
  input  logic             retire,
  input  logic [REG_W-1:0] retire_idx,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  output logic             hazard,
  output logic             sb_ovf,
  output logic             sb_unf
);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [NREG-1:0]  pend;

  logic same_reg;
  logic inc_eff;
  logic ret_eff;
  logic inc_sat;
  logic ret_empty;

  // An issue and a retire on the same register cancel, so neither can
  // saturate or underflow that counter.
  assign same_reg  = inc & retire & (inc_idx == retire_idx);
  assign inc_eff   = inc & ~same_reg;
  assign ret_eff   = retire & ~same_reg;
  assign inc_sat   = inc_eff & (cnt_q[inc_idx] == CNT_MAX);
  assign ret_empty = ret_eff & (cnt_q[retire_idx] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      sb_ovf <= 1'b0;
      sb_unf <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (inc_eff && !inc_sat && (inc_idx == REG_W'(i))) begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end else if (ret_eff && !ret_empty && (retire_idx == REG_W'(i))) begin
          cnt_q[i] <= cnt_q[i] - CNT_ONE;
        end
      end
      sb_ovf <= sb_ovf | inc_sat;
      sb_unf <= sb_unf | ret_empty;
    end
  end

  // The last outstanding write is committed on this cycle's falling edge,
  // so decode can already read it and need not stall.
  always_comb begin
    pend = '0;
    for (int i = 0; i < NREG; i++) begin
      pend[i] = (cnt_q[i] != '0) &
                ~((cnt_q[i] == CNT_ONE) & retire & (retire_idx == REG_W'(i)));
    end
  end

  assign hazard = pend[src1] | (two_src & pend[src2]);

endmodule

// File: rtl/wb_scoreboard_stage.sv
// MEM/WB pipeline register, writeback value select and register-file write
// port, plus the pending-write scoreboard used by decode to stall.
module wb_scoreboard_stage
  import wb_scoreboard_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              mem_wb_en,
  input  logic              mem_r_en,
  input  logic [DATA_W-1:0] mem_alu_res,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [REG_W-1:0]  mem_dest,
  input  logic              issue_en,
  input  logic              issue_wb,
  input  logic [REG_W-1:0]  issue_dest,
  input  logic [REG_W-1:0]  src1,
  input  logic [REG_W-1:0]  src2,
  input  logic              two_src,
  output logic              WB_EN,
  output logic [REG_W-1:0]  destWB,
  output logic [DATA_W-1:0] valueWB,
  output logic              hazard,
  output logic              sb_ovf,
  output logic              sb_unf
);

  logic              wb_en_q;
  logic              r_en_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] rdata_q;
  reg_idx_t          dest_q;
  logic              fresh_q;
  logic              inc;

  // fresh_q marks the first cycle an instruction sits in MEM/WB; a frozen
  // instruction stays put but must only write and retire once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q <= 1'b0;
      r_en_q  <= 1'b0;
      alu_q   <= '0;
      rdata_q <= '0;
      dest_q  <= '0;
      fresh_q <= 1'b0;
    end else if (!freeze) begin
      wb_en_q <= mem_wb_en;
      r_en_q  <= mem_r_en;
      alu_q   <= mem_alu_res;
      rdata_q <= mem_rdata;
      dest_q  <= mem_dest;
      fresh_q <= 1'b1;
    end else begin
      fresh_q <= 1'b0;
    end
  end

  assign WB_EN   = wb_en_q & fresh_q;
  assign destWB  = dest_q;
  assign valueWB = r_en_q ? rdata_q : alu_q;

  // issue_en is a single-cycle qualifier with no back-pressure of its own:
  // a transfer happens on any rising edge where issue_en=1 and freeze=0.
  assign inc = issue_en & issue_wb & ~freeze;

  wb_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .inc        (inc),
    .inc_idx    (issue_dest),
    .retire     (WB_EN),
    .retire_idx (dest_q),
    .src1       (src1),
    .src2       (src2),
    .two_src    (two_src),
    .hazard     (hazard),
    .sb_ovf     (sb_ovf),
    .sb_unf     (sb_unf)
  );

endmodule

// File: tb/tb_wb_scoreboard_stage.sv
// Directed bench for wb_scoreboard_stage: writeback path, retire-once under
// freeze, RAW hazard with negedge bypass, inc/retire collision, saturation and async reset.
module tb_wb_scoreboard_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        mem_wb_en;
  logic        mem_r_en;
  logic [31:0] mem_alu_res;
  logic [31:0] mem_rdata;
  logic [3:0]  mem_dest;
  logic        issue_en;
  logic        issue_wb;
  logic [3:0]  issue_dest;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;
  logic        WB_EN;
  logic [3:0]  destWB;
  logic [31:0] valueWB;
  logic        hazard;
  logic        sb_ovf;
  logic        sb_unf;

  int checks = 0;
  int errors = 0;

  wb_scoreboard_stage dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .mem_wb_en   (mem_wb_en),
    .mem_r_en    (mem_r_en),
    .mem_alu_res (mem_alu_res),
    .mem_rdata   (mem_rdata),
    .mem_dest    (mem_dest),
    .issue_en    (issue_en),
    .issue_wb    (issue_wb),
    .issue_dest  (issue_dest),
    .src1        (src1),
    .src2        (src2),
    .two_src     (two_src),
    .WB_EN       (WB_EN),
    .destWB      (destWB),
    .valueWB     (valueWB),
    .hazard      (hazard),
    .sb_ovf      (sb_ovf),
    .sb_unf      (sb_unf)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic wb, input logic rd, input logic [31:0] alu,
                         input logic [31:0] rdat, input logic [3:0] dst);
    mem_wb_en   = wb;
    mem_r_en    = rd;
    mem_alu_res = alu;
    mem_rdata   = rdat;
    mem_dest    = dst;
  endtask

  task automatic set_issue(input logic en, input logic [3:0] dst);
    issue_en   = en;
    issue_wb   = en;
    issue_dest = dst;
  endtask

  initial begin
    rst = 1'b1;
    freeze = 1'b0;
    set_mem(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    set_issue(1'b0, 4'd0);
    src1 = 4'd0;
    src2 = 4'd0;
    two_src = 1'b0;

    #3;
    chk("rst_wb_en", WB_EN, 0);
    chk("rst_dest", destWB, 0);
    chk("rst_value", valueWB, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_ovf", sb_ovf, 0);
    chk("rst_unf", sb_unf, 0);
    #9 rst = 1'b0;

    // 1: ALU writeback to r3 (issued the same cycle so retire is balanced)
    set_issue(1'b1, 4'd3);
    set_mem(1'b1, 1'b0, 32'h0000_00A5, 32'h0, 4'd3);
    tick();
    set_issue(1'b0, 4'd0);
    set_mem(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    src1 = 4'd3;
    #1;
    chk("alu_wb_en", WB_EN, 1);
    chk("alu_dest", destWB, 3);
    chk("alu_value", valueWB, 32'hA5);
    chk("alu_cnt3", dut.u_sb.cnt_q[3], 1);
    chk("alu_bypass_hazard", hazard, 0);
    tick();
    chk("alu_idle_wb_en", WB_EN, 0);
    chk("alu_cnt3_after", dut.u_sb.cnt_q[3], 0);
    src1 = 4'd0;

    // 2: load data selected over ALU result
    set_issue(1'b1, 4'd4);
    set_mem(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'd4);
    tick();
    set_issue(1'b0, 4'd0);
    set_mem(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    chk("ld_value", valueWB, 32'hDEADBEEF);
    chk("ld_dest", destWB, 4);
    chk("ld_wb_en", WB_EN, 1);
    tick();
    chk("ld_cnt4_after", dut.u_sb.cnt_q[4], 0);

    // 3: frozen instruction retires exactly once
    set_issue(1'b1, 4'd5);
    tick();
    set_issue(1'b0, 4'd0);
    chk("frz_cnt5_issued", dut.u_sb.cnt_q[5], 1);
    set_mem(1'b1, 1'b0, 32'h0000_0055, 32'h0, 4'd5);
    tick();
    set_mem(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    chk("frz_first_wb_en", WB_EN, 1);
    freeze = 1'b1;
    tick();
    chk("frz_hold1_wb_en", WB_EN, 0);
    chk("frz_cnt5_retired", dut.u_sb.cnt_q[5], 0);
    chk("frz_hold_dest", destWB, 5);
    tick();
    chk("frz_hold2_wb_en", WB_EN, 0);
    set_issue(1'b1, 4'd6);
    tick();
    set_issue(1'b0, 4'd0);
    chk("frz_hold3_wb_en", WB_EN, 0);
    chk("frz_cnt5_final", dut.u_sb.cnt_q[5], 0);
    chk("frz_issue_blocked", dut.u_sb.cnt_q[6], 0);
    chk("frz_unf", sb_unf, 0);
    freeze = 1'b0;
    tick();

    // 4: RAW hazard on r2 with two writes in flight
    set_issue(1'b1, 4'd2);
    tick();
    tick();
    set_issue(1'b0, 4'd0);
    chk("raw_cnt2", dut.u_sb.cnt_q[2], 2);
    src1 = 4'd2;
    #1;
    chk("raw_hazard_src1", hazard, 1);
    src1 = 4'd0;
    src2 = 4'd2;
    two_src = 1'b0;
    #1;
    chk("raw_src2_ignored", hazard, 0);
    two_src = 1'b1;
    #1;
    chk("raw_src2_used", hazard, 1);
    two_src = 1'b0;
    src2 = 4'd0;
    src1 = 4'd2;
    set_mem(1'b1, 1'b0, 32'h0000_0022, 32'h0, 4'd2);
    tick();
    chk("raw_ret1_wb_en", WB_EN, 1);
    chk("raw_ret1_hazard", hazard, 1);
    set_mem(1'b1, 1'b0, 32'h0000_0023, 32'h0, 4'd2);
    tick();
    set_mem(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    chk("raw_ret2_cnt", dut.u_sb.cnt_q[2], 1);
    chk("raw_ret2_wb_en", WB_EN, 1);
    chk("raw_ret2_bypass", hazard, 0);
    tick();
    chk("raw_done_cnt", dut.u_sb.cnt_q[2], 0);
    chk("raw_done_hazard", hazard, 0);
    src1 = 4'd0;

    // 5: issue and retire r7 in the same cycle
    set_issue(1'b1, 4'd7);
    set_mem(1'b1, 1'b0, 32'h0000_0077, 32'h0, 4'd7);
    tick();
    set_mem(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    chk("col_cnt7_pre", dut.u_sb.cnt_q[7], 1);
    chk("col_wb_en", WB_EN, 1);
    tick();
    set_issue(1'b0, 4'd0);
    chk("col_cnt7", dut.u_sb.cnt_q[7], 1);
    chk("col_ovf", sb_ovf, 0);
    chk("col_unf", sb_unf, 0);

    // 6: saturate r1, then asynchronous reset mid-cycle
    set_issue(1'b1, 4'd1);
    tick();
    tick();
    tick();
    chk("sat_cnt3", dut.u_sb.cnt_q[1], 3);
    chk("sat_ovf_clear", sb_ovf, 0);
    set_mem(1'b1, 1'b0, 32'h0000_0011, 32'h0, 4'd1);
    tick();
    set_issue(1'b0, 4'd0);
    set_mem(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    src1 = 4'd1;
    #1;
    chk("sat_cnt_hold", dut.u_sb.cnt_q[1], 3);
    chk("sat_ovf", sb_ovf, 1);
    chk("sat_wb_en", WB_EN, 1);
    chk("sat_hazard", hazard, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_wb_en", WB_EN, 0);
    chk("arst_hazard", hazard, 0);
    chk("arst_ovf", sb_ovf, 0);
    chk("arst_dest", destWB, 0);
    chk("arst_value", valueWB, 0);
    chk("arst_cnt1", dut.u_sb.cnt_q[1], 0);
    chk("arst_cnt7", dut.u_sb.cnt_q[7], 0);
    #4 rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
